id_ex_pipe_reg: RTL
===================

// Module: id_ex_pipe_reg
// PURPOSE
//  ID/EX stage boundary of the 16-bit pipelined processor. Captures decode outputs (register operands,
//  PC+2, dest addr, control word) and builds the 16-bit immediate from the instruction word.
//  The extension forms are zero-5b, sign-5b, zero-8b, sign-8b and sign-11b. Feeds execute.
//  Implements stall, flush and bubble insertion. Runs a halt state machine and a sticky illegal-extend error.
// PARAMETERS
//  CTRL_W    8        width of opaque control word passed to EX (bit 0 = reg write enable)
//  HALT_OP   5'b00000 opcode (instr[15:11]) that halts the pipe
// PORTS
//  clk         in   1       clock; all state updates on posedge
//  rst         in   1       synchronous, active-high reset
//  id_valid    in   1       decode slot holds a real instruction
//  id_instr    in   16      instruction word from IF/ID
//  id_pc_inc   in   16      PC+2 of the instruction
//  id_rs_data  in   16      register file read port 1
//  id_rt_data  in   16      register file read port 2
//  id_rd_addr  in   3       destination register
//  id_ext_sel  in   3       immediate form select (see BEHAVIOUR)
//  id_ctrl     in   CTRL_W  decoded control word
//  stall       in   1       hold current EX contents
//  flush       in   1       replace EX contents with bubble
//  ex_valid    out  1       EX slot valid
//  ex_pc_inc   out  16      registered id_pc_inc
//  ex_rs_data  out  16      registered id_rs_data
//  ex_rt_data  out  16      registered id_rt_data
//  ex_imm      out  16      registered extended immediate
//  ex_rd_addr  out  3       registered id_rd_addr
//  ex_ctrl     out  CTRL_W  registered id_ctrl; all-zero in a bubble
//  ex_halt     out  1       pipe halted (HALT instruction reached EX)
//  err         out  1       sticky: illegal id_ext_sel on a loaded valid instruction
// BEHAVIOUR
//  Reset: every output = 0; state = RUN.
//  Latency: 1 cycle, ID inputs at edge N appear on ex_* after edge N.
//  Extension (combinational on id_instr; bits zero/sign filled to 16):
//   000 zero instr[4:0]; 001 sign instr[4:0]; 010 zero instr[7:0]; 011 sign instr[7:0];
//   100 sign instr[10:0]; 101-111 illegal -> ex_imm=0.
//  Per-edge priority: rst > flush > HALTED hold > stall > load.
//   flush: load bubble (ex_valid=0, ex_ctrl=0, other data regs 0). Flush beats stall.
//     In HALTED, flush also returns to RUN and clears ex_halt.
//   stall (no flush): all ex_* and state unchanged.
//   load: ex_* <= ID values; ex_valid <= id_valid.
//     If id_valid=0, load bubble instead.
//  Illegal ext_sel on a valid load: load bubble and set err. err clears only on rst.
//   Stalled or flushed illegal inputs do not set err.
//  FSM (2 states):
//   RUN -> HALTED on a valid load with id_instr[15:11]==HALT_OP.
//     HALT is loaded normally (ex_valid=1) and ex_halt<=1.
//   HALTED: every non-flush edge loads a bubble and ignores stall and ID inputs.
//     ex_halt stays 1. Flush -> RUN. rst -> RUN.
//  Simultaneous flush with incoming HALT: flush wins; no halt.
//  Reset mid-stall or in HALTED: outputs 0 next edge; no residual state.
// STRUCTURE
//  Shared pkg/defines file: EXT_* select codes, HALT_OP, CTRL_W, state encodings RUN/HALTED.
//  Sub-module imm_ext_16 (combinational, instr+sel -> imm, illegal flag).
//    It reuses the existing zero-extend 5b block for form 000.
//  Top: one always block for regs + FSM, no latches, no async logic.
// TESTING (bench uses clkrst; drive inputs on posedge, check on negedge, like other benches)
//  Load: valid, instr=16'h4A1F, sel=000, rs=16'h1234 -> next cycle ex_imm=16'h001F, ex_rs_data=16'h1234, ex_valid=1.
//  Sign forms: instr[7:0]=8'h80, sel=011 -> ex_imm=16'hFF80.
//    instr[10:0]=11'h400, sel=100 -> 16'hFC00.
//    sel=001 with instr[4:0]=5'h10 -> 16'hFFF0.
//  Stall 3 cycles with changing inputs -> ex_* frozen. flush+stall same edge -> ex_valid=0, ex_ctrl=0.
//  Illegal sel=110, valid -> bubble and err=1. err holds through later legal loads and clears only on rst.
//  HALT (instr=16'h0000, valid) -> ex_valid=1, ex_halt=1. Next 4 cycles bubbles despite valid inputs.
//    Flush -> RUN and ex_halt=0. The next legal load passes through.
//  rst asserted in HALTED and mid-stall -> all outputs 0 after the edge. Random soak 3200 ns vs reference model.

Source files
------------

// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared definitions for the ID/EX boundary:
// immediate form codes, halt opcode, slot bundle.
package id_ex_pipe_reg_pkg;

  localparam int         CTRL_W_DEF  = 8;
  localparam logic [4:0] HALT_OP_DEF = 5'b00000;

  localparam logic [2:0] EXT_Z5  = 3'b000;
  localparam logic [2:0] EXT_S5  = 3'b001;
  localparam logic [2:0] EXT_Z8  = 3'b010;
  localparam logic [2:0] EXT_S8  = 3'b011;
  localparam logic [2:0] EXT_S11 = 3'b100;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  typedef struct packed {
    logic        valid;
    logic [15:0] pc_inc;
    logic [15:0] rs_data;
    logic [15:0] rt_data;
    logic [15:0] imm;
    logic [2:0]  rd_addr;
  } id_ex_t;

  localparam id_ex_t ID_EX_BUBBLE = '0;

endpackage

// File: rtl/id_ex_pipe_reg_imm_ext.sv
// Immediate builder: instruction word plus form
// select gives the 16-bit immediate and an illegal flag.
module zext_5b (
  input  logic [4:0]  in,
  output logic [15:0] out
);

  assign out = {11'b0, in};

endmodule

module imm_ext_16
  import id_ex_pipe_reg_pkg::*;
(
  input  logic [15:0] instr,
  input  logic [2:0]  sel,
  output logic [15:0] imm,
  output logic        illegal
);

  logic [15:0] z5;

  zext_5b u_zext_5b (
    .in  (instr[4:0]),
    .out (z5)
  );

  // Select the extension form; unknown codes give zero.
  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    unique case (sel)
      EXT_Z5:  imm = z5;
      EXT_S5:  imm = {{11{instr[4]}}, instr[4:0]};
      EXT_Z8:  imm = {8'b0, instr[7:0]};
      EXT_S8:  imm = {{8{instr[7]}}, instr[7:0]};
      EXT_S11: imm = {{5{instr[10]}}, instr[10:0]};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with stall, flush,
// bubble insertion, halt FSM and sticky err.
module id_ex_pipe_reg
  import id_ex_pipe_reg_pkg::*;
#(
  parameter int         CTRL_W  = CTRL_W_DEF,
  parameter logic [4:0] HALT_OP = HALT_OP_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [15:0]       id_instr,
  input  logic [15:0]       id_pc_inc,
  input  logic [15:0]       id_rs_data,
  input  logic [15:0]       id_rt_data,
  input  logic [2:0]        id_rd_addr,
  input  logic [2:0]        id_ext_sel,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              stall,
  input  logic              flush,
  output logic              ex_valid,
  output logic [15:0]       ex_pc_inc,
  output logic [15:0]       ex_rs_data,
  output logic [15:0]       ex_rt_data,
  output logic [15:0]       ex_imm,
  output logic [2:0]        ex_rd_addr,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_halt,
  output logic              err
);

  logic [15:0] imm;
  logic        illegal;
  logic        is_halt;
  id_ex_t      id_d;
  id_ex_t      ex_q;
  logic [CTRL_W-1:0] ctrl_q;
  state_t      state;

  imm_ext_16 u_imm_ext_16 (
    .instr   (id_instr),
    .sel     (id_ext_sel),
    .imm     (imm),
    .illegal (illegal)
  );

  assign is_halt = (id_instr[15:11] == HALT_OP);

  assign id_d = '{
    valid:   1'b1,
    pc_inc:  id_pc_inc,
    rs_data: id_rs_data,
    rt_data: id_rt_data,
    imm:     imm,
    rd_addr: id_rd_addr
  };

  // Slot registers and halt FSM, priority
  // rst > flush > halted > stall > load.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q   <= ID_EX_BUBBLE;
      ctrl_q <= '0;
      state  <= RUN;
      err    <= 1'b0;
    end else if (flush) begin
      ex_q   <= ID_EX_BUBBLE;
      ctrl_q <= '0;
      state  <= RUN;
    end else if (state == HALTED) begin
      ex_q   <= ID_EX_BUBBLE;
      ctrl_q <= '0;
    end else if (!stall) begin
      unique case (1'b1)
        !id_valid: begin
          ex_q   <= ID_EX_BUBBLE;
          ctrl_q <= '0;
        end
        illegal: begin
          ex_q   <= ID_EX_BUBBLE;
          ctrl_q <= '0;
          err    <= 1'b1;
        end
        default: begin
          ex_q   <= id_d;
          ctrl_q <= id_ctrl;
          if (is_halt) state <= HALTED;
        end
      endcase
    end
  end

  assign ex_valid   = ex_q.valid;
  assign ex_pc_inc  = ex_q.pc_inc;
  assign ex_rs_data = ex_q.rs_data;
  assign ex_rt_data = ex_q.rt_data;
  assign ex_imm     = ex_q.imm;
  assign ex_rd_addr = ex_q.rd_addr;
  assign ex_ctrl    = ctrl_q;
  assign ex_halt    = (state == HALTED);

endmodule
